tile_blitter: RTL and testbench

TILE_BLITTER -- requirements
Module: tile_blitter

---
 rtl/tile_blitter.sv | 116 +++++++++++
 tb/tb_tile_blitter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_blitter.sv
// Tile blitter: streams an 8x8 tile from ROM into the framebuffer with
// per-pixel clipping, transparency and optional horizontal mirroring.
module tile_blitter #(
  parameter int         FB_W        = 160,
  parameter int         FB_H        = 120,
  parameter logic [7:0] TRANSPARENT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_x,
  input  logic [7:0]  req_y,
  input  logic [5:0]  req_tile,
  input  logic        req_flip,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DRAIN
  } state_t;

  localparam logic [9:0] W10 = 10'(FB_W);
  localparam logic [9:0] H10 = 10'(FB_H);

  state_t      state;
  logic [5:0]  p;
  logic [5:0]  tile_q;
  logic        flip_q;
  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic        ready_q;
  logic        done_q;
  logic        pv;
  logic        in_q;
  logic [15:0] addr_q;

  logic [2:0]  row;
  logic [2:0]  col;
  logic [9:0]  xs;
  logic [9:0]  ys;
  logic [15:0] lin;

  assign row = p[5:3];
  assign col = p[2:0];

  // 10-bit sums so an off-screen x never wraps back on screen
  assign xs  = {1'b0, x_q} + {7'b0, col};
  assign ys  = {2'b0, y_q} + {7'b0, row};
  assign lin = 16'(32'(ys) * FB_W + 32'(xs));

  assign rom_addr = {tile_q, row, flip_q ? ~col : col};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      p       <= '0;
      tile_q  <= '0;
      flip_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pv      <= 1'b0;
      in_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      pv     <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            tile_q  <= req_tile;
            flip_q  <= req_flip;
            x_q     <= req_x;
            y_q     <= req_y;
            p       <= '0;
            ready_q <= 1'b0;
            state   <= DRAW;
          end
        end
        DRAW: begin
          pv     <= 1'b1;
          in_q   <= (xs < W10) && (ys < H10);
          addr_q <= lin;
          p      <= p + 6'd1;
          if (p == 6'd63) begin
            done_q <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write slot: ROM data for the pixel issued last cycle arrives now
  assign fb_we     = pv && in_q && (rom_data != TRANSPARENT);
  assign fb_addr   = fb_we ? addr_q : '0;
  assign fb_data   = fb_we ? rom_data : '0;
  assign done      = done_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_tile_blitter.sv
// Bench for tile_blitter: table of draw requests plus reset and
// back-to-back sequences, checked against a write scoreboard.
module tb_tile_blitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [8:0]  req_x = '0;
  logic [7:0]  req_y = '0;
  logic [5:0]  req_tile = '0;
  logic        req_flip = 1'b0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        done;

  tile_blitter dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_tile (req_tile),
    .req_flip (req_flip),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:4095];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int x, y, tile, flip;
    int nw, fa, la, ff;
    int pa, pd, pa2, pd2;
  } vec_t;

  wr_t  exp_q[$];
  int   done_exp[$];
  wr_t  wlog[$];
  int   n_done;
  int   checks;
  int   failures;
  vec_t tv[6];

  task automatic check(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_expect(int x, int y, int t, int f, int acc);
    int r, c, rc, pix;
    for (int p = 0; p < 64; p++) begin
      r   = p / 8;
      c   = p % 8;
      rc  = f ? 7 - c : c;
      pix = int'(rom[t * 64 + r * 8 + rc]);
      if (pix != 0 && x + c < 160 && y + r < 120)
        exp_q.push_back('{acc + p + 2, (y + r) * 160 + x + c, pix});
    end
    done_exp.push_back(acc + 65);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        done_exp.delete();
        continue;
      end
      if (req_valid && req_ready)
        push_expect(int'(req_x), int'(req_y), int'(req_tile),
                    int'(req_flip), cyc);
      if (fb_we) begin
        wlog.push_back('{cyc, int'(fb_addr), int'(fb_data)});
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(fb_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", int'(fb_addr), e.addr);
          check("wr_data", int'(fb_data), e.data);
        end
      end
      if (done) begin
        n_done++;
        if (done_exp.size() == 0)
          check("unexpected_done", cyc, -1);
        else
          check("done_cycle", cyc, done_exp.pop_front());
      end
    end
  endtask

  task automatic wait_accept(output int acc);
    bit ok;
    ok  = 1'b0;
    acc = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    check("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_ready(int acc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_timeout", int'(ok), 1);
    check("ready_cycle", cyc - acc, 66);
  endtask

  task automatic do_req(int x, int y, int t, int f, output int acc);
    @(posedge clk);
    #1;
    req_x     = 9'(x);
    req_y     = 8'(y);
    req_tile  = 6'(t);
    req_flip  = f[0];
    req_valid = 1'b1;
    wait_accept(acc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x     = 9'($urandom);
    req_y     = 8'($urandom);
    req_tile  = 6'($urandom);
    req_flip  = 1'($urandom);
  endtask

  function automatic int probe(int s, int a);
    int r;
    r = -1;
    for (int i = s; i < wlog.size(); i++)
      if (wlog[i].addr == a) r = wlog[i].data;
    return r;
  endfunction

  task automatic run_row(int i);
    int s, d, acc, nw, ff, oob;
    s = wlog.size();
    d = n_done;
    do_req(tv[i].x, tv[i].y, tv[i].tile, tv[i].flip, acc);
    wait_ready(acc);
    nw  = wlog.size() - s;
    ff  = 0;
    oob = 0;
    for (int k = s; k < wlog.size(); k++) begin
      if (wlog[k].data == 8'hFF) ff++;
      if (wlog[k].addr >= 19200) oob++;
    end
    check($sformatf("row%0d_writes", i), nw, tv[i].nw);
    check($sformatf("row%0d_first", i), nw > 0 ? wlog[s].addr : -1, tv[i].fa);
    check($sformatf("row%0d_last", i),
          nw > 0 ? wlog[wlog.size() - 1].addr : -1, tv[i].la);
    check($sformatf("row%0d_ff", i), ff, tv[i].ff);
    check($sformatf("row%0d_oob", i), oob, 0);
    check($sformatf("row%0d_probe", i), probe(s, tv[i].pa), tv[i].pd);
    check($sformatf("row%0d_probe2", i), probe(s, tv[i].pa2), tv[i].pd2);
    check($sformatf("row%0d_dones", i), n_done - d, 1);
  endtask

  initial begin
    int acc, acc2, s, d, fw;
    checks   = 0;
    failures = 0;
    n_done   = 0;

    for (int i = 0; i < 4096; i++) rom[i] = 8'h55;
    for (int i = 0; i < 64; i++) begin
      rom[64 + i]  = 8'hE0;
      rom[128 + i] = (i == 0) ? 8'h1C : 8'h03;
      rom[256 + i] = (((i / 8) ^ (i % 8)) & 1) != 0 ? 8'hFF : 8'h00;
    end

    //     x    y    t  f  nw  first  last   ff  probe          probe2
    tv[0] = '{10,  5,  1, 0, 64, 810,   1937,  0,  810,  8'hE0, 1937,  8'hE0};
    tv[1] = '{0,   0,  2, 1, 64, 0,     1127,  0,  7,    8'h1C, 0,     8'h03};
    tv[2] = '{156, 116, 1, 0, 16, 18716, 19199, 0, 18716, 8'hE0, 19199, 8'hE0};
    tv[3] = '{20,  20, 4, 0, 32, 3221,  4346,  32, 3221, 8'hFF, 3220,  -1};
    tv[4] = '{511, 0,  1, 0, 0,  -1,    -1,    0,  511,  -1,    0,     -1};
    tv[5] = '{0,  115, 1, 0, 40, 18400, 19047, 0,  18400, 8'hE0, 19047, 8'hE0};

    fork
      monitor();
    join_none

    #1 rst = 1'b0;
    #1;
    check("rst_ready", int'(req_ready), 0);
    check("rst_we", int'(fb_we), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(req_ready), 1);

    for (int i = 0; i < 6; i++) run_row(i);

    // reset in the middle of a draw
    d = n_done;
    do_req(0, 0, 1, 0, acc);
    for (int i = 0; i < 100; i++) begin
      if (cyc == acc + 30) break;
      @(negedge clk);
    end
    check("pre_rst_we", int'(fb_we), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_we", int'(fb_we), 0);
    check("mid_rst_ready", int'(req_ready), 0);
    check("mid_rst_rom_addr", int'(rom_addr), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", int'(req_ready), 1);
    repeat (80) @(negedge clk);
    check("abandoned_dones", n_done - d, 0);
    run_row(0);

    // back-to-back with req_valid held high
    s = wlog.size();
    d = n_done;
    @(posedge clk);
    #1;
    req_x     = 9'd30;
    req_y     = 8'd30;
    req_tile  = 6'd1;
    req_flip  = 1'b0;
    req_valid = 1'b1;
    wait_accept(acc);
    @(posedge clk);
    #1;
    req_x = 9'd50;
    req_y = 8'd50;
    @(negedge clk);
    wait_accept(acc2);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_ready(acc2);
    check("b2b_accept_gap", acc2 - acc, 66);
    fw = -1;
    for (int k = s; k < wlog.size(); k++)
      if (wlog[k].cyc > acc2 && fw < 0) fw = wlog[k].cyc;
    check("b2b_first_write", fw - acc2, 2);
    check("b2b_writes", wlog.size() - s, 128);
    check("b2b_dones", n_done - d, 2);

    repeat (4) @(negedge clk);
    check("left_writes", exp_q.size(), 0);
    check("left_dones", done_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
